// File: rtl/vector_store_if.sv
// Handshake and memory-write bundle for the vector store unit.
// master: the requester / memory side; slave: the store unit itself.
interface vector_store_if #(
    parameter int WIDTH_V    = 128,
    parameter int BITS_INDEX = 8,
    parameter int ADDR_W     = 32
) ();
    logic                  start;
    logic [WIDTH_V-1:0]    vec_in;
    logic [ADDR_W-1:0]     base_addr;
    logic                  mem_ready;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [BITS_INDEX-1:0] mem_wdata;
    logic                  busy;
    logic                  done;

    modport master (
        output start, vec_in, base_addr, mem_ready,
        input  mem_we, mem_addr, mem_wdata, busy, done
    );

    modport slave (
        input  start, vec_in, base_addr, mem_ready,
        output mem_we, mem_addr, mem_wdata, busy, done
    );
endinterface

// File: rtl/vector_store_unit.sv
// Vector store unit: latches a packed vector and a base byte address on
// start, then writes the elements one per accepted cycle to consecutive
// byte addresses (element 0 first, MSB-aligned), stalling on mem_ready.
// A one-cycle done pulse follows the last accepted write.
module vector_store_unit #(
    parameter int WIDTH_V    = 128,
    parameter int BITS_INDEX = 8,
    parameter int ADDR_W     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    vector_store_if.slave   bus
);
    localparam int NUM_ELEMENTS = WIDTH_V / BITS_INDEX;
    localparam int IDX_W        = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_r;
    logic [IDX_W-1:0]      idx_r;
    logic [WIDTH_V-1:0]    vec_r;
    logic [ADDR_W-1:0]     base_r;
    logic                  mem_we_r;
    logic [ADDR_W-1:0]     mem_addr_r;
    logic [BITS_INDEX-1:0] mem_wdata_r;
    logic                  busy_r;
    logic                  done_r;
    logic [IDX_W-1:0]      next_idx_s;

    // Element k sits k slots below the top of the packed vector.
    function automatic logic [BITS_INDEX-1:0] element_at(
        input logic [WIDTH_V-1:0] vec,
        input logic [IDX_W-1:0]   k
    );
        logic [WIDTH_V-1:0] shifted;
        shifted = vec << (BITS_INDEX * int'(k));
        return shifted[WIDTH_V-1 -: BITS_INDEX];
    endfunction

    // Index of the element to present after the current one is accepted.
    always_comb begin
        next_idx_s = idx_r + IDX_W'(1);
    end

    // Control FSM with all outputs registered; addresses wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            vec_r       <= '0;
            base_r      <= '0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r     <= WRITE;
                        vec_r       <= bus.vec_in;
                        base_r      <= bus.base_addr;
                        idx_r       <= '0;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= bus.base_addr;
                        mem_wdata_r <= element_at(bus.vec_in, '0);
                        busy_r      <= 1'b1;
                    end else begin
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= '0;
                        mem_wdata_r <= '0;
                        busy_r      <= 1'b0;
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        if (idx_r == LAST_IDX) begin
                            state_r     <= DONE;
                            mem_we_r    <= 1'b0;
                            mem_addr_r  <= '0;
                            mem_wdata_r <= '0;
                            done_r      <= 1'b1;
                        end else begin
                            idx_r       <= next_idx_s;
                            mem_addr_r  <= base_r + ADDR_W'(next_idx_s);
                            mem_wdata_r <= element_at(vec_r, next_idx_s);
                        end
                    end else begin
                        // Stall: current write stays on the bus unchanged.
                        idx_r <= idx_r;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    idx_r   <= '0;
                end
                default: begin
                    state_r     <= IDLE;
                    idx_r       <= '0;
                    mem_we_r    <= 1'b0;
                    mem_addr_r  <= '0;
                    mem_wdata_r <= '0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule
